pm_cmd_initiator: RTL and testbench

- Initiator side of the pm-style mode/condition control interface.
- Accepts a 2-bit command from a host over a valid/ready handshake and drives the encoded mode lines (l, m, n) and the arm line (k) toward a responder.
- After a programmable settle window it samples the responder's grant/fault status, retries on no-response, and returns a result record over a second valid/ready handshake.
- Sits between the host control logic and a combinational pm responder.

---
 rtl/pm_cmd_initiator.sv | 203 ++++++++++++++++++++
 tb/tb_pm_cmd_initiator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pm_cmd_initiator.sv
// pm_cmd_initiator: host-side driver of the pm mode/arm lines with retry.
// Optional odd-parity check on responder status: define PM_CMD_PARITY_EN.
module pm_cmd_initiator #(
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 3,
  parameter int TRY_W      = 3
) (
  input  logic             pclk,
  input  logic             prst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_arm,
  output logic             mode_l,
  output logic             mode_m,
  output logic             mode_n,
  output logic             arm_k,
  input  logic             rsp_grant,
  input  logic             rsp_fault,
`ifdef PM_CMD_PARITY_EN
  input  logic             rsp_par,
  output logic             par_err,
`endif
  output logic             done_valid,
  input  logic             done_ready,
  output logic             done_ok,
  output logic             done_fault,
  output logic [TRY_W-1:0] done_tries,
  output logic             busy
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SET_LAST =
    (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;
  localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_RETRY + 1);
  localparam logic [3:0] IDLE_CODE = 4'b1000;
  localparam logic [1:0] OP_NOP = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       op_q;
  logic             arm_q;
  logic [3:0]       lines_q;
  logic [3:0]       lines_d;
  logic [TRY_W-1:0] tries_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             ok_q;
  logic             fault_q;
  logic             take;
  logic             inc_try;
  logic             set_res;
  logic             res_ok;
  logic             res_fault;
  logic             par_ok;
  logic [1:0]       op_src;
  logic             arm_src;

  function automatic logic [3:0] code_of(
    input logic [1:0] op,
    input logic       arm
  );
    logic [3:0] c;
    unique case (op)
      2'b00:   c = IDLE_CODE;
      2'b01:   c = {3'b000, arm};
      2'b10:   c = {3'b011, arm};
      default: c = {3'b010, arm};
    endcase
    return c;
  endfunction

`ifdef PM_CMD_PARITY_EN
  assign par_ok = rsp_grant ^ rsp_fault ^ rsp_par;
`else
  assign par_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state, handshake decisions and next line code
  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    inc_try   = 1'b0;
    set_res   = 1'b0;
    res_ok    = 1'b0;
    res_fault = 1'b0;
    cnt_d     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          take    = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (op_q == OP_NOP) begin
          state_d = S_DONE;
          set_res = 1'b1;
          res_ok  = 1'b1;
        end else if (SETTLE_CYC > 0) begin
          state_d = S_SETTLE;
        end else begin
          state_d = S_SAMPLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SET_LAST) state_d = S_SAMPLE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      S_SAMPLE: begin
        if (par_ok && rsp_fault) begin
          state_d   = S_DONE;
          set_res   = 1'b1;
          res_fault = 1'b1;
        end else if (par_ok && rsp_grant) begin
          state_d = S_DONE;
          set_res = 1'b1;
          res_ok  = 1'b1;
        end else if (tries_q < TRY_MAX) begin
          state_d = S_GAP;
        end else begin
          state_d = S_DONE;
          set_res = 1'b1;
        end
      end
      S_GAP: begin
        inc_try = 1'b1;
        state_d = S_DRIVE;
      end
      S_DONE: begin
        if (done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    op_src  = take ? cmd_op : op_q;
    arm_src = take ? cmd_arm : arm_q;
    if (state_d inside {S_DRIVE, S_SETTLE, S_SAMPLE})
      lines_d = code_of(op_src, arm_src);
    else
      lines_d = IDLE_CODE;
  end

  // Registered lines, latched command, counters and result
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      lines_q <= IDLE_CODE;
      op_q    <= OP_NOP;
      arm_q   <= 1'b0;
      tries_q <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      lines_q <= lines_d;
      cnt_q   <= cnt_d;
      if (take) begin
        op_q    <= cmd_op;
        arm_q   <= cmd_arm;
        tries_q <= TRY_W'(1);
      end else if (inc_try) begin
        tries_q <= tries_q + TRY_W'(1);
      end
      if (set_res) begin
        ok_q    <= res_ok;
        fault_q <= res_fault;
      end
    end
  end

`ifdef PM_CMD_PARITY_EN
  // Sticky flag for a status sample with broken parity
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n)
      par_err <= 1'b0;
    else if (state_q == S_SAMPLE && !par_ok)
      par_err <= 1'b1;
  end
`endif

  assign {mode_l, mode_m, mode_n, arm_k} = lines_q;
  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done_valid = (state_q == S_DONE);
  assign done_ok    = ok_q;
  assign done_fault = fault_q;
  assign done_tries = tries_q;

endmodule

// File: tb/tb_pm_cmd_initiator.sv
// tb_pm_cmd_initiator: directed bench with a result scoreboard.
// Parity ports are tied to good parity when PM_CMD_PARITY_EN is set.
module tb_pm_cmd_initiator;

  localparam int TRY_W = 3;

  typedef struct packed {
    logic             ok;
    logic             fault;
    logic [TRY_W-1:0] tries;
  } res_t;

  logic             pclk = 1'b0;
  logic             prst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_arm;
  logic             mode_l;
  logic             mode_m;
  logic             mode_n;
  logic             arm_k;
  logic             rsp_grant;
  logic             rsp_fault;
  logic             done_valid;
  logic             done_ready;
  logic             done_ok;
  logic             done_fault;
  logic [TRY_W-1:0] done_tries;
  logic             busy;
`ifdef PM_CMD_PARITY_EN
  logic             rsp_par;
  logic             par_err;
  assign rsp_par = ~(rsp_grant ^ rsp_fault);
`endif

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  pm_cmd_initiator #(
    .SETTLE_CYC(2),
    .MAX_RETRY (3),
    .TRY_W     (TRY_W)
  ) dut (
    .pclk      (pclk),
    .prst_n    (prst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arm   (cmd_arm),
    .mode_l    (mode_l),
    .mode_m    (mode_m),
    .mode_n    (mode_n),
    .arm_k     (arm_k),
    .rsp_grant (rsp_grant),
    .rsp_fault (rsp_fault),
`ifdef PM_CMD_PARITY_EN
    .rsp_par   (rsp_par),
    .par_err   (par_err),
`endif
    .done_valid(done_valid),
    .done_ready(done_ready),
    .done_ok   (done_ok),
    .done_fault(done_fault),
    .done_tries(done_tries),
    .busy      (busy)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] lines();
    return {mode_l, mode_m, mode_n, arm_k};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic arm);
    @(negedge pclk);
    chk("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arm   = arm;
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_result(input int max_cyc);
    res_t exp;
    int   n;
    n = 0;
    while (!done_valid && n < max_cyc) begin
      @(negedge pclk);
      n++;
    end
    checks++;
    if (!done_valid) begin
      errors++;
      $display("FAIL done_timeout: observed done_valid=0 expected 1");
      return;
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: observed result expected none");
      return;
    end
    exp = sb.pop_front();
    chk("done_ok", done_ok, exp.ok);
    chk("done_fault", done_fault, exp.fault);
    chk("done_tries", done_tries, exp.tries);
    done_ready = 1'b1;
    @(negedge pclk);
    done_ready = 1'b0;
    chk("valid_after_hs", done_valid, 1'b0);
    chk("ready_after_hs", cmd_ready, 1'b1);
  endtask

  initial begin
    prst_n     = 1'b0;
    cmd_valid  = 1'b1;
    cmd_op     = 2'b11;
    cmd_arm    = 1'b0;
    rsp_grant  = 1'b1;
    rsp_fault  = 1'b0;
    done_ready = 1'b0;

    // reset with a pending command
    repeat (3) @(negedge pclk);
    chk("rst_lines", lines(), 4'b1000);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_valid", done_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tries", done_tries, 3'd0);
    chk("rst_ok", done_ok, 1'b0);
    sb.push_back('{ok: 1'b1, fault: 1'b0, tries: 3'd1});
    prst_n = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b0;
    chk("first_edge_busy", busy, 1'b1);
    chk("first_edge_ready", cmd_ready, 1'b0);
    chk("first_edge_lines", lines(), 4'b0100);
    get_result(10);
    rsp_grant = 1'b0;

    // ARM arm=1, grant from cycle 3, exact latency
    sb.push_back('{ok: 1'b1, fault: 1'b0, tries: 3'd1});
    send(2'b10, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge pclk);
      if (c == 2) begin
        cmd_op  = 2'b00;
        cmd_arm = 1'b0;
      end
      if (c == 3) rsp_grant = 1'b1;
      chk($sformatf("arm_lines_c%0d", c), lines(), 4'b0111);
      chk($sformatf("arm_valid_c%0d", c), done_valid, 1'b0);
    end
    @(negedge pclk);
    chk("arm_valid_c5", done_valid, 1'b1);
    chk("arm_lines_c5", lines(), 4'b1000);
    get_result(0);
    rsp_grant = 1'b0;

    // QUERY with no response: four tries, one idle gap between
    sb.push_back('{ok: 1'b0, fault: 1'b0, tries: 3'd4});
    send(2'b11, 1'b0);
    for (int c = 1; c <= 19; c++) begin
      if (c > 1) @(negedge pclk);
      if (c == 2) begin
        cmd_op  = 2'b10;
        cmd_arm = 1'b1;
      end
      chk($sformatf("qry_lines_c%0d", c), lines(),
          (c % 5 == 0) ? 4'b1000 : 4'b0100);
      chk($sformatf("qry_valid_c%0d", c), done_valid, 1'b0);
    end
    @(negedge pclk);
    chk("qry_valid_c20", done_valid, 1'b1);
    get_result(0);

    // LOAD with grant and fault together: fault wins
    rsp_grant = 1'b1;
    rsp_fault = 1'b1;
    sb.push_back('{ok: 1'b0, fault: 1'b1, tries: 3'd1});
    send(2'b01, 1'b0);
    chk("load_lines", lines(), 4'b0000);
    get_result(10);
    rsp_grant = 1'b0;
    rsp_fault = 1'b0;

    // NOP with host back-pressure on the result
    sb.push_back('{ok: 1'b1, fault: 1'b0, tries: 3'd1});
    send(2'b00, 1'b1);
    chk("nop_valid_c1", done_valid, 1'b0);
    chk("nop_lines_c1", lines(), 4'b1000);
    @(negedge pclk);
    chk("nop_valid_c2", done_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      chk("nop_hold_valid", done_valid, 1'b1);
      chk("nop_hold_ok", done_ok, 1'b1);
      chk("nop_hold_tries", done_tries, 3'd1);
      chk("nop_hold_ready", cmd_ready, 1'b0);
    end
    get_result(0);

    // reset during SETTLE of the second try
    send(2'b11, 1'b1);
    repeat (6) @(negedge pclk);
    chk("abort_lines_pre", lines(), 4'b0101);
    #2 prst_n = 1'b0;
    #1;
    chk("abort_lines", lines(), 4'b1000);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", cmd_ready, 1'b1);
    repeat (2) @(negedge pclk);
    prst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge pclk);
      chk("abort_no_valid", done_valid, 1'b0);
      chk("abort_idle", busy, 1'b0);
    end
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
